// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding and default width.
package mul_pkg;

  localparam int MUL_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

  // Counter width needed to index WIDTH shift steps; never narrower than one bit.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Operand, accumulator and step-counter registers for the shift-add multiplier.
// Driven by load/step strobes from the controller in mul_unit.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = cnt_bits(WIDTH);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_addend   = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign o_last     = (r_cnt == CW'(WIDTH - 1));
  assign o_product  = r_product;

  // The product register only moves on the final step, so it holds across IDLE and CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (o_last) begin
        r_product <= w_acc_next;
      end
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Sequential unsigned shift-add multiplier: IDLE -> CALC (WIDTH steps) -> DONE -> IDLE.
// busy and done are registered so no input reaches them combinationally.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mul_state_t r_state;
  mul_state_t w_next_state;
  logic       r_busy;
  logic       r_done;
  logic       w_load;
  logic       w_step;
  logic       w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
      // done trails the DONE state by one edge, landing in the first IDLE cycle.
      r_done  <= (r_state == DONE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (a),
    .i_b      (b),
    .o_last   (w_last),
    .o_product(product)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mul_unit.sv
// Directed and random checks of mul_unit: expected products queued at start, compared on done.
module tb_mul_unit;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int             n_assert;
  int             n_fail;
  int             done_cnt;
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] last_prod;
  logic           prev_done;

  mul_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected product at each done, checks pulse width and idle hold.
  initial begin
    last_prod = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_prod = '0;
        prev_done = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
          chk("done_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (q.size() > 0) begin
            chk("sb_product", {16'b0, product}, {16'b0, q.pop_front()});
          end
          last_prod = product;
        end else if (!busy) begin
          chk("product_hold", {16'b0, product}, {16'b0, last_prod});
        end
        prev_done = done;
      end
    end
  end

  // Called at a negedge with busy low; returns the number of edges from start edge to done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    int lat;
    logic [2*W-1:0] e;
    e = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = W'($urandom);
    b_i   = W'($urandom);
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 30);
    chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    chk({tag, "_latency"}, lat - 1, LAT);
    chk({tag, "_product"}, {16'b0, product}, {16'b0, e});
  endtask

  initial begin
    int dc;
    n_assert = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_i      = '0;
    b_i      = '0;

    // Reset state, held for three cycles
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_product", {16'b0, product}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_busy", {31'b0, busy}, 0);
      chk("rst_hold_done", {31'b0, done}, 0);
      chk("rst_hold_product", {16'b0, product}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and extremes
    run_op(8'd3, 8'd5, "basic");
    run_op(8'd255, 8'd255, "max");
    run_op(8'd0, 8'd200, "zero_a");
    run_op(8'd1, 8'd128, "one_msb");
    run_op(8'd200, 8'd0, "zero_b");

    // Start while busy must be ignored
    dc = done_cnt;
    a_i   = 8'd7;
    b_i   = 8'd6;
    start = 1'b1;
    q.push_back(16'd42);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_in_calc", {31'b0, busy}, 1);
    a_i   = 8'd9;
    b_i   = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 30);
    end
    chk("busy_start_product", {16'b0, product}, 42);
    repeat (4) @(negedge clk);
    chk("busy_start_one_done", done_cnt - dc, 1);
    chk("busy_start_queue", q.size(), 0);
    run_op(8'd2, 8'd3, "after_busy");

    // Reset in the middle of an operation
    dc = done_cnt;
    a_i   = 8'd10;
    b_i   = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_product", {16'b0, product}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc, 0);
    chk("midrst_idle_busy", {31'b0, busy}, 0);
    run_op(8'd12, 8'd12, "after_rst");

    // Back-to-back random operations, each issued as soon as busy drops
    dc = done_cnt;
    for (int i = 0; i < 200; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
    end
    repeat (5) @(negedge clk);
    chk("rand_done_count", done_cnt - dc, 200);
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
